// File: rtl/regfile_hilo.sv
`default_nettype none
// ==========================================================================
// regfile_hilo : 32x32 GPR file plus HI/LO registers with optional
//                same-cycle write forwarding and a committed-write counter.
// Revision 1.0
// ==========================================================================
module regfile_hilo #(
  parameter int RF_BYPASS   = 1,
  parameter int HILO_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [37:0] wb_to_rf_bus,
  input  logic [65:0] hilo_bus,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] wr_count
);

  localparam int c_nregs = 32;

  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_rf_commit;
  logic        w_hi_we;
  logic        w_lo_we;
  logic [31:0] w_hi_wdata;
  logic [31:0] w_lo_wdata;
  logic [31:0] w_arr1;
  logic [31:0] w_arr2;

  logic [31:0] r_gpr [c_nregs];
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_wr_count;

  assign w_rf_we     = wb_to_rf_bus[37];
  assign w_rf_waddr  = wb_to_rf_bus[36:32];
  assign w_rf_wdata  = wb_to_rf_bus[31:0];
  assign w_rf_commit = w_rf_we && (w_rf_waddr != 5'd0);

  assign w_hi_we    = hilo_bus[65];
  assign w_lo_we    = hilo_bus[64];
  assign w_hi_wdata = hilo_bus[63:32];
  assign w_lo_wdata = hilo_bus[31:0];

  // Reset wins over any write presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_nregs; i++) r_gpr[i] <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rf_commit) begin
        r_gpr[w_rf_waddr] <= w_rf_wdata;
        r_wr_count        <= r_wr_count + 32'd1;
      end
      if (w_hi_we) r_hi <= w_hi_wdata;
      if (w_lo_we) r_lo <= w_lo_wdata;
    end
  end

  // GPR 0 is hardwired to zero regardless of array contents.
  assign w_arr1 = (raddr1 == 5'd0) ? 32'd0 : r_gpr[raddr1];
  assign w_arr2 = (raddr2 == 5'd0) ? 32'd0 : r_gpr[raddr2];

  generate
    if (RF_BYPASS != 0) begin : g_rf_bypass
      logic w_hit1;
      logic w_hit2;
      assign w_hit1 = w_rf_commit && (raddr1 == w_rf_waddr);
      assign w_hit2 = w_rf_commit && (raddr2 == w_rf_waddr);
      assign rdata1 = w_hit1 ? w_rf_wdata : w_arr1;
      assign rdata2 = w_hit2 ? w_rf_wdata : w_arr2;
    end else begin : g_rf_direct
      assign rdata1 = w_arr1;
      assign rdata2 = w_arr2;
    end
  endgenerate

  generate
    if (HILO_BYPASS != 0) begin : g_hilo_bypass
      assign hi_o = w_hi_we ? w_hi_wdata : r_hi;
      assign lo_o = w_lo_we ? w_lo_wdata : r_lo;
    end else begin : g_hilo_direct
      assign hi_o = r_hi;
      assign lo_o = r_lo;
    end
  endgenerate

  assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_hilo.sv
`default_nettype none
// tb_regfile_hilo : directed vector table, wrap corner case and random traffic
// checked against an architectural model of the register file.
module tb_regfile_hilo;

  logic        clk;
  logic        rst;
  logic [37:0] wb_to_rf_bus;
  logic [65:0] hilo_bus;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, wr_count;
  logic [31:0] nb_rdata1, nb_rdata2, nb_hi_o, nb_lo_o, nb_wr_count;

  regfile_hilo dut (
    .clk(clk), .rst(rst), .wb_to_rf_bus(wb_to_rf_bus), .hilo_bus(hilo_bus),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .wr_count(wr_count)
  );

  regfile_hilo #(.RF_BYPASS(0), .HILO_BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wb_to_rf_bus(wb_to_rf_bus), .hilo_bus(hilo_bus),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2),
    .hi_o(nb_hi_o), .lo_o(nb_lo_o), .wr_count(nb_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural state: what a program would observe after each edge.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo, m_cnt;

  typedef struct {
    logic        rst;
    logic [37:0] wb;
    logic [65:0] hl;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2, ehi, elo, ecnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wb_to_rf_bus[37] && wb_to_rf_bus[36:32] == a) return wb_to_rf_bus[31:0];
    return m_gpr[a];
  endfunction

  task automatic apply(input logic r, input logic [37:0] wb, input logic [65:0] hl,
                       input logic [4:0] a1, input logic [4:0] a2);
    rst = r; wb_to_rf_bus = wb; hilo_bus = hl; raddr1 = a1; raddr2 = a2;
    #1;
  endtask

  task automatic model_check();
    chk("rdata1",    rdata1,    exp_rd(raddr1, 1'b1));
    chk("rdata2",    rdata2,    exp_rd(raddr2, 1'b1));
    chk("hi_o",      hi_o,      hilo_bus[65] ? hilo_bus[63:32] : m_hi);
    chk("lo_o",      lo_o,      hilo_bus[64] ? hilo_bus[31:0]  : m_lo);
    chk("wr_count",  wr_count,  m_cnt);
    chk("nb_rdata1", nb_rdata1, exp_rd(raddr1, 1'b0));
    chk("nb_rdata2", nb_rdata2, exp_rd(raddr2, 1'b0));
    chk("nb_hi_o",   nb_hi_o,   m_hi);
    chk("nb_lo_o",   nb_lo_o,   m_lo);
    chk("nb_wr_count", nb_wr_count, m_cnt);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      foreach (m_gpr[i]) m_gpr[i] = '0;
      m_hi = '0; m_lo = '0; m_cnt = '0;
    end else begin
      if (wb_to_rf_bus[37] && wb_to_rf_bus[36:32] != 5'd0) begin
        m_gpr[wb_to_rf_bus[36:32]] = wb_to_rf_bus[31:0];
        m_cnt = m_cnt + 32'd1;
      end
      if (hilo_bus[65]) m_hi = hilo_bus[63:32];
      if (hilo_bus[64]) m_lo = hilo_bus[31:0];
    end
    @(negedge clk);
  endtask

  initial begin
    logic [37:0] wb;
    logic [65:0] hl;
    logic [4:0]  a1, a2;

    //          rst   wb                                 hl                                             a1     a2     e1            e2            ehi           elo           ecnt
    tbl[0]  = '{1'b0, {1'b1, 5'd5, 32'h12345678},        66'd0,                                         5'd5,  5'd0,  32'h12345678, 32'h0,        32'h0,        32'h0,        32'd0};
    tbl[1]  = '{1'b0, 38'd0,                             66'd0,                                         5'd5,  5'd5,  32'h12345678, 32'h12345678, 32'h0,        32'h0,        32'd1};
    tbl[2]  = '{1'b0, {1'b1, 5'd0, 32'hFFFFFFFF},        66'd0,                                         5'd0,  5'd5,  32'h0,        32'h12345678, 32'h0,        32'h0,        32'd1};
    tbl[3]  = '{1'b0, 38'd0,                             66'd0,                                         5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'd1};
    tbl[4]  = '{1'b0, {1'b1, 5'd7, 32'hA5A5A5A5},        66'd0,                                         5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        32'd1};
    tbl[5]  = '{1'b0, 38'd0,                             66'd0,                                         5'd7,  5'd5,  32'hA5A5A5A5, 32'h12345678, 32'h0,        32'h0,        32'd2};
    tbl[6]  = '{1'b0, 38'd0, {1'b1, 1'b0, 32'hDEADBEEF, 32'h11111111},                                  5'd0,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        32'd2};
    tbl[7]  = '{1'b0, 38'd0, {1'b0, 1'b0, 32'h0, 32'h0},                                                5'd0,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        32'd2};
    tbl[8]  = '{1'b0, 38'd0, {1'b1, 1'b1, 32'd1, 32'd2},                                                5'd0,  5'd0,  32'h0,        32'h0,        32'd1,        32'd2,        32'd2};
    tbl[9]  = '{1'b0, 38'd0,                             66'd0,                                         5'd0,  5'd0,  32'h0,        32'h0,        32'd1,        32'd2,        32'd2};
    tbl[10] = '{1'b0, {1'b0, 5'd9, 32'hCAFEF00D},        66'd0,                                         5'd9,  5'd0,  32'h0,        32'h0,        32'd1,        32'd2,        32'd2};
    tbl[11] = '{1'b1, {1'b1, 5'd3, 32'h00000055}, {1'b1, 1'b1, 32'd9, 32'd9},                           5'd3,  5'd7,  32'h55,       32'hA5A5A5A5, 32'd9,        32'd9,        32'd2};
    tbl[12] = '{1'b0, 38'd0,                             66'd0,                                         5'd3,  5'd7,  32'h0,        32'h0,        32'h0,        32'h0,        32'd0};

    rst = 1'b1; wb_to_rf_bus = '0; hilo_bus = '0; raddr1 = '0; raddr2 = '0;
    foreach (m_gpr[i]) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0; m_cnt = '0;

    @(negedge clk);
    apply(1'b1, 38'd0, 66'd0, 5'd0, 5'd0);
    advance();
    // A single reset edge must be enough to reach a fully cleared state.
    for (int a = 0; a < 32; a += 4) begin
      apply(1'b0, 38'd0, 66'd0, 5'(a), 5'(a + 1));
      chk("reset_rd1", rdata1, 32'd0);
      chk("reset_rd2", rdata2, 32'd0);
      model_check();
      advance();
    end

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].rst, tbl[i].wb, tbl[i].hl, tbl[i].a1, tbl[i].a2);
      chk($sformatf("vec%0d_rdata1", i), rdata1, tbl[i].e1);
      chk($sformatf("vec%0d_rdata2", i), rdata2, tbl[i].e2);
      chk($sformatf("vec%0d_hi", i), hi_o, tbl[i].ehi);
      chk($sformatf("vec%0d_lo", i), lo_o, tbl[i].elo);
      chk($sformatf("vec%0d_count", i), wr_count, tbl[i].ecnt);
      model_check();
      advance();
    end

    // Non-bypassed instance: old GPR7 in the write cycle, new one afterwards.
    apply(1'b0, {1'b1, 5'd7, 32'h0BADF00D}, 66'd0, 5'd7, 5'd7);
    chk("nb_old_value", nb_rdata1, 32'h0);
    chk("byp_new_value", rdata2, 32'h0BADF00D);
    model_check();
    advance();
    apply(1'b0, 38'd0, 66'd0, 5'd7, 5'd0);
    chk("nb_next_value", nb_rdata1, 32'h0BADF00D);
    model_check();
    advance();

    // Counter wrap: preload the counter, then commit one write.
    force dut.r_wr_count = 32'hFFFFFFFF;
    force dut_nb.r_wr_count = 32'hFFFFFFFF;
    #1;
    release dut.r_wr_count;
    release dut_nb.r_wr_count;
    m_cnt = 32'hFFFFFFFF;
    apply(1'b0, {1'b1, 5'd12, 32'h00C0FFEE}, 66'd0, 5'd12, 5'd0);
    chk("wrap_pre", wr_count, 32'hFFFFFFFF);
    model_check();
    advance();
    apply(1'b0, 38'd0, 66'd0, 5'd12, 5'd0);
    chk("wrap_post", wr_count, 32'h0);
    chk("wrap_data", rdata1, 32'h00C0FFEE);
    model_check();
    advance();

    for (int n = 0; n < 400; n++) begin
      wb = {1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7) * 4 % 32 + $urandom_range(0, 1)), $urandom()};
      hl = {2'($urandom()), $urandom(), $urandom()};
      if ($urandom_range(0, 15) == 0) wb = '0;
      if ($urandom_range(0, 15) == 0) hl = '0;
      a1 = ($urandom_range(0, 2) == 0) ? wb[36:32] : 5'($urandom());
      a2 = ($urandom_range(0, 2) == 0) ? wb[36:32] : 5'($urandom());
      apply(1'($urandom_range(0, 40) == 0), wb, hl, a1, a2);
      model_check();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
